// File: rtl/gray_ctrl_pkg.sv
// Shared types and helpers for the shared Gray-counter arbiter.
package gray_ctrl_pkg;

  localparam int STATE_W    = 2;
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_arbiter_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or after i_ptr wins.
module rr_arbiter #(
  parameter  int NREQ  = 4,
  localparam int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt
);

  logic        w_found;
  int unsigned w_sel;

  // NOTE: every variable driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_sel   = 0;
    for (int off = 0; off < NREQ; off++) begin
      w_sel = (int'(i_ptr) + off) % NREQ;
      if (!w_found && i_req[PTR_W'(w_sel)]) begin
        o_gnt[PTR_W'(w_sel)] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_counter_arbiter.sv
// One WIDTH-bit Gray counter shared by NREQ requesters through a round-robin grant.
// Optional down-counting per burst is enabled with the GRAY_DOWN_EN macro.
module gray_counter_arbiter
  import gray_ctrl_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] req_steps,
`ifdef GRAY_DOWN_EN
  input  logic [NREQ-1:0]       req_dir,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      gray,
  output logic                  gray_valid,
  output logic [NREQ-1:0]       done
);

  localparam int PTR_W = $clog2(NREQ);

  state_t             r_state;
  state_t             w_state_next;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    r_done;
  logic [WIDTH-1:0]   r_bin;
  logic [WIDTH-1:0]   r_gray;
  logic               r_gray_valid;
  logic [CNT_W-1:0]   r_rem;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_ptr;

  logic [NREQ-1:0]    w_arb_gnt;
  logic [PTR_W-1:0]   w_arb_idx;
  logic [PTR_W-1:0]   w_ptr_after;
  logic               w_owner_req;
  logic [CNT_W-1:0]   w_steps;
  logic [WIDTH-1:0]   w_bin_next;
  logic [WIDTH-1:0]   w_gray_next;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_arb_gnt[i]) w_arb_idx = PTR_W'(i);
    end
  end

  assign w_ptr_after = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
  assign w_owner_req = req[r_owner];
  assign w_steps     = req_steps[int'(r_owner)*CNT_W +: CNT_W];

`ifdef GRAY_DOWN_EN
  logic r_dir;
  assign w_bin_next = r_dir ? r_bin - 1'b1 : r_bin + 1'b1;
`else
  assign w_bin_next = r_bin + 1'b1;
`endif
  assign w_gray_next = WIDTH'(bin2gray(GRAY_MAX_W'(w_bin_next)));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (|req) w_state_next = LOAD;
      LOAD: begin
        if (!w_owner_req)        w_state_next = IDLE;
        else if (w_steps == '0)  w_state_next = DONE;
        else                     w_state_next = RUN;
      end
      RUN: begin
        if (!w_owner_req)                  w_state_next = IDLE;
        else if (r_rem == CNT_W'(1))       w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt        <= '0;
      r_done       <= '0;
      r_bin        <= '0;
      r_gray       <= '0;
      r_gray_valid <= 1'b0;
      r_rem        <= '0;
      r_owner      <= '0;
      r_ptr        <= '0;
`ifdef GRAY_DOWN_EN
      r_dir        <= 1'b0;
`endif
    end else begin
      r_gray_valid <= 1'b0;
      r_done       <= (w_state_next == DONE) ? r_gnt : '0;
      unique case (r_state)
        IDLE: begin
          if (|req) begin
            r_gnt   <= w_arb_gnt;
            r_owner <= w_arb_idx;
          end
        end
        LOAD: begin
          if (!w_owner_req) begin
            r_gnt <= '0;
            r_ptr <= w_ptr_after;
          end else begin
            r_rem <= w_steps;
`ifdef GRAY_DOWN_EN
            r_dir <= req_dir[r_owner];
`endif
          end
        end
        RUN: begin
          // An abort leaves the last stepped code visible and still rotates priority.
          if (!w_owner_req) begin
            r_gnt <= '0;
            r_ptr <= w_ptr_after;
          end else begin
            r_bin        <= w_bin_next;
            r_gray       <= w_gray_next;
            r_gray_valid <= 1'b1;
            r_rem        <= r_rem - 1'b1;
          end
        end
        DONE: begin
          r_gnt <= '0;
          r_ptr <= w_ptr_after;
        end
        default: ;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign gray       = r_gray;
  assign gray_valid = r_gray_valid;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_gray_counter_arbiter.sv
// Directed bench with a code scoreboard for gray_counter_arbiter (GRAY_DOWN_EN optional).
module tb_gray_counter_arbiter;

  localparam int WIDTH = 3;
  localparam int NREQ  = 4;
  localparam int CNT_W = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_steps;
  logic [NREQ-1:0]       req_dir;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic [WIDTH-1:0]      gray;
  logic                  gray_valid;
  logic [NREQ-1:0]       done;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] obs_log[$];
  logic [WIDTH-1:0] model_bin;
  bit               model_dir;

  gray_counter_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_steps  (req_steps),
`ifdef GRAY_DOWN_EN
    .req_dir    (req_dir),
`endif
    .gnt        (gnt),
    .busy       (busy),
    .gray       (gray),
    .gray_valid (gray_valid),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_codes(input int n);
    for (int k = 0; k < n; k++) begin
      model_bin = model_dir ? model_bin - 1'b1 : model_bin + 1'b1;
      exp_q.push_back(model_bin ^ (model_bin >> 1));
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    req_dir = '0;
    tick();
    exp_q.delete();
    model_bin = '0;
    model_dir = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  // Full burst by requester r; optionally rewrites its step count after LOAD.
  task automatic burst(input int r, input int n, input bit poke, input string tag);
    int cyc;
    req_steps[r*CNT_W +: CNT_W] = CNT_W'(n);
    req[r] = 1'b1;
    push_codes(n);
    tick();
    check({tag, "_gnt"}, 32'(gnt), 32'(1 << r));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    if (poke) begin
      tick();
      cyc = 1;
      req_steps[r*CNT_W +: CNT_W] = '1;
    end
    while (done == '0 && cyc < n + 6) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, 32'(done), 32'(1 << r));
    check({tag, "_latency"}, 32'(cyc), 32'(n + 1));
    req[r] = 1'b0;
    tick();
    check({tag, "_gnt_released"}, 32'(gnt), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_code;
    if (rst_n) begin
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (gray_valid) begin
        obs_log.push_back(gray);
        if (exp_q.size() == 0) begin
          check("gray_unexpected", 32'(gray_valid), 32'd0);
        end else begin
          exp_code = exp_q.pop_front();
          check("gray_seq", 32'(gray), 32'(exp_code));
        end
      end
      if (done != '0) check("done_to_owner", 32'(done), 32'(gnt));
    end
  end

  initial begin
    #200000;
    check("watchdog", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [WIDTH-1:0] t3_exp [9];
    t3_exp = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};

    rst_n     = 1'b0;
    req       = '0;
    req_dir   = '0;
    req_steps = '0;
    model_bin = '0;
    model_dir = 1'b0;
    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gray", 32'(gray), 32'd0);
    check("rst_valid", 32'(gray_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single burst of 3 from reset
    burst(0, 3, 1'b0, "t1");
    check("t1_gray_end", 32'(gray), 32'h2);

    // 2: all requesting, one step each, round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NREQ; i++) req_steps[i*CNT_W +: CNT_W] = CNT_W'(1);
    push_codes(5);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      cyc = 0;
      while (gnt == '0 && cyc < 8) begin tick(); cyc++; end
      check("t2_grant_order", 32'(gnt), 32'(1 << (k % NREQ)));
      cyc = 0;
      while (done == '0 && cyc < 8) begin tick(); cyc++; end
      check("t2_done", 32'(done), 32'(1 << (k % NREQ)));
      if (k == 4) req = '0;
      tick();
    end
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);

    // 3: 9 steps wrap seamlessly; step count rewritten mid-burst is ignored
    do_reset();
    obs_log.delete();
    burst(2, 9, 1'b1, "t3");
    check("t3_count", 32'(obs_log.size()), 32'd9);
    for (int i = 0; i < 9 && i < obs_log.size(); i++)
      check("t3_wrap_seq", 32'(obs_log[i]), 32'(t3_exp[i]));

    // 4: zero steps -> done pulse, gray untouched
    burst(3, 0, 1'b0, "t4");
    check("t4_gray_held", 32'(gray), 32'h1);

    // 5: abort after 2 of 5 steps, next owner continues from 011
    do_reset();
    req_steps[1*CNT_W +: CNT_W] = CNT_W'(5);
    req[1] = 1'b1;
    push_codes(2);
    tick();
    check("t5_gnt", 32'(gnt), 32'h2);
    tick();
    tick();
    tick();
    req[1] = 1'b0;
    tick();
    check("t5_abort_gnt", 32'(gnt), 32'd0);
    check("t5_abort_idle", 32'(busy), 32'd0);
    check("t5_abort_gray", 32'(gray), 32'h3);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t5_no_done", 32'(done), 32'd0);
      tick();
    end
    burst(0, 1, 1'b0, "t5b");
    check("t5_continue", 32'(gray), 32'h2);

    // 6: reset mid-RUN returns to reset values at once
    do_reset();
    req_steps[2*CNT_W +: CNT_W] = CNT_W'(5);
    req[2] = 1'b1;
    push_codes(5);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_gray", 32'(gray), 32'd0);
    check("t6_gnt", 32'(gnt), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(gray_valid), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    req = '0;
    exp_q.delete();
    model_bin = '0;
    tick();
    rst_n = 1'b1;
    tick();
`ifdef GRAY_DOWN_EN
    req_dir[0] = 1'b1;
    model_dir  = 1'b1;
    burst(0, 2, 1'b0, "t6_down");
    check("t6_down_gray", 32'(gray), 32'h5);
    req_dir[0] = 1'b0;
    model_dir  = 1'b0;
`else
    burst(1, 2, 1'b0, "t6_up");
    check("t6_up_gray", 32'(gray), 32'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
